mem_port_arbiter: RTL and testbench

//  Shares one memory port between the instruction-side (I) and data-side (D) cache controllers.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-side and D-side cache controllers, one access in flight.
// Optional ARB_ROUND_ROBIN_EN: alternate on contention; otherwise D-side has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  owner,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       i_act;
  logic       d_act;
  logic       win;
  logic       win_write;

  // win is only consumed when someone is active; falling back to last_grant keeps it tracked
  always_comb begin
    i_act = i_read | i_write;
    d_act = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_act && d_act)
      win = ~last_grant;
    else if (i_act || d_act)
      win = d_act;
    else
      win = last_grant;
`else
    if (i_act || d_act)
      win = d_act;
    else
      win = last_grant;
`endif
    win_write = win ? d_write : i_write;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_act || d_act) begin
            owner     <= win;
            mem_addr  <= win ? d_addr : i_addr;
            mem_wdata <= win ? d_wdata : i_wdata;
            mem_write <= win_write;
            mem_read  <= ~win_write;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= owner;
            if (owner) begin
              d_ready <= 1'b1;
              if (mem_read) d_rdata <= mem_rdata;
            end else begin
              i_ready <= 1'b1;
              if (mem_read) i_rdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // requests are ignored here so a requester can drop its level after ready
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model with cycle-count timing rules.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
  logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0, i_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          i_ready, d_ready, mem_read, mem_write, owner, busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one access record plus edge-count timing rules.
  int          e = 0;
  bit          m_out, m_own, m_wr, m_last, m_iready, m_dready;
  logic [31:0] m_addr, m_wd, m_irdata, m_drdata;
  int          m_grant_edge, m_next_grant, m_done;

  task automatic model_reset();
    m_out = 0; m_own = 0; m_wr = 0; m_last = 1; m_iready = 0; m_dready = 0;
    m_addr = '0; m_wd = '0; m_irdata = '0; m_drdata = '0;
    m_grant_edge = -1; m_next_grant = 0; m_done = -1;
  endtask

  task automatic model_edge();
    bit ia, da, w;
    ia = i_read | i_write;
    da = d_read | d_write;
    m_iready = 0;
    m_dready = 0;
    if (!m_out) begin
      if (e >= m_next_grant && (ia || da)) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (ia && da) w = !m_last;
        else          w = da;
`else
        w = da;
`endif
        m_own = w;
        m_out = 1;
        m_grant_edge = e;
        m_wr   = w ? d_write : i_write;
        m_addr = w ? d_addr : i_addr;
        m_wd   = w ? d_wdata : i_wdata;
      end
    end else if (e > m_grant_edge && mem_ready) begin
      if (m_own) begin
        m_dready = 1;
        if (!m_wr) m_drdata = mem_rdata;
      end else begin
        m_iready = 1;
        if (!m_wr) m_irdata = mem_rdata;
      end
      m_last = m_own;
      m_out = 0;
      m_done = e;
      m_next_grant = e + 2;
    end
  endtask

  task automatic compare();
    check("mem_read",  32'(mem_read),  32'(m_out && !m_wr));
    check("mem_write", 32'(mem_write), 32'(m_out && m_wr));
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wd);
    check("owner",     32'(owner), 32'(m_own));
    check("busy",      32'(busy),  32'(m_out || (e == m_done)));
    check("i_ready",   32'(i_ready), 32'(m_iready));
    check("d_ready",   32'(d_ready), 32'(m_dready));
    check("i_rdata",   i_rdata, m_irdata);
    check("d_rdata",   d_rdata, m_drdata);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    e++;
    model_edge();
    compare();
  endtask

  task automatic drive(input logic rdy, inout logic rd, inout logic wr,
                       inout logic [31:0] a, inout logic [31:0] wd, inout bit hold);
    if (hold) begin
      rd = 0; wr = 0; hold = 0;
    end else if (rd || wr) begin
      if (rdy) begin
        if ($urandom_range(1, 0) == 1) hold = 1;
        else begin rd = 0; wr = 0; end
      end else if ($urandom_range(39, 0) == 0) begin
        rd = 0; wr = 0;
      end
    end else if ($urandom_range(3, 0) == 0) begin
      case ($urandom_range(2, 0))
        0:       begin rd = 1; wr = 0; end
        1:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      a = $urandom;
      wd = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          exp_own[3];
    bit          i_hold = 0, d_hold = 0;
    logic [31:0] d_prev;
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{1'b0, 1'b1, 1'b0};
`else
    exp_own = '{1'b1, 1'b1, 1'b1};
`endif
    model_reset();
    #12;
    compare();
    reset = 0;

    // I read alone, memory answers three cycles after the strobe
    i_read = 1; i_addr = 32'h100;
    step();
    check("t1_strobe", 32'(mem_read), 32'd1);
    step(); step();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    step();
    check("t1_i_ready", 32'(i_ready), 32'd1);
    check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    check("t1_d_ready", 32'(d_ready), 32'd0);
    i_read = 0; mem_ready = 0;
    step();
    check("t1_pulse", 32'(i_ready), 32'd0);
    step();

    // D write, memory ready on the strobe cycle
    d_write = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
    d_prev = d_rdata;
    step();
    check("t2_write", 32'(mem_write), 32'd1);
    check("t2_wdata", mem_wdata, 32'h12345678);
    mem_ready = 1;
    step();
    check("t2_write_drop", 32'(mem_write), 32'd0);
    check("t2_d_ready", 32'(d_ready), 32'd1);
    check("t2_d_rdata", d_rdata, d_prev);
    d_write = 0; mem_ready = 0;
    step(); step();

    // both read together, held for three rounds
    i_read = 1; i_addr = 32'h300; d_read = 1; d_addr = 32'h400;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4 && mem_read !== 1'b1; k++) step();
      check("t3_strobe", 32'(mem_read), 32'd1);
      check("t3_owner", 32'(owner), 32'(exp_own[r]));
      mem_ready = 1; mem_rdata = 32'hA000 + 32'(r);
      step();
      mem_ready = 0;
    end
    i_read = 0; d_read = 0;
    step(); step();

    // D arrives while I is busy: its strobe follows the i_ready pulse by two cycles
    i_read = 1; i_addr = 32'h500;
    step();
    d_read = 1; d_addr = 32'h600;
    step();
    mem_ready = 1; mem_rdata = 32'h55;
    step();
    check("t4_i_ready", 32'(i_ready), 32'd1);
    i_read = 0; mem_ready = 0;
    step();
    check("t4_gap", 32'(mem_read), 32'd0);
    step();
    check("t4_d_strobe", 32'(mem_read), 32'd1);
    check("t4_owner", 32'(owner), 32'd1);
    mem_ready = 1; mem_rdata = 32'h66;
    step();
    d_read = 0; mem_ready = 0;
    step(); step();

    // reset while busy: strobes drop without waiting for a clock
    i_read = 1; i_addr = 32'h700;
    step();
    step();
    reset = 1;
    #1;
    check("t5_mem_read", 32'(mem_read), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_i_ready", 32'(i_ready), 32'd0);
    model_reset();
    compare();
    #1;
    reset = 0; i_read = 0; mem_ready = 1;
    step(); step();
    mem_ready = 0;
    step();

    // request held one cycle past ready must not start a second access
    i_read = 1; i_addr = 32'h800;
    step();
    mem_ready = 1; mem_rdata = 32'h77;
    step();
    check("t6_i_ready", 32'(i_ready), 32'd1);
    mem_ready = 0;
    step();
    i_read = 0;
    step();
    check("t6_no_dup", 32'(mem_read), 32'd0);
    step();
    check("t6_no_dup2", 32'(mem_read), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(i_ready, i_read, i_write, i_addr, i_wdata, i_hold);
      drive(d_ready, d_read, d_write, d_addr, d_wdata, d_hold);
      if (mem_read || mem_write) mem_ready = ($urandom_range(2, 0) == 0);
      else                       mem_ready = ($urandom_range(7, 0) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
